// File: rtl/adder_share_arbiter.sv
// Round-robin share of one 8-bit ripple-carry adder between N_REQ valid/ready requesters.
// Accept -> registered response one edge later; the response holds until rsp_ready_i, and no new request is taken meanwhile.

module adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [8:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[8];
endmodule

module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic [8*N_REQ-1:0] req_a_i,
    input  logic [8*N_REQ-1:0] req_b_i,
    input  logic [N_REQ-1:0]   req_cin_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [7:0]         rsp_sum_o,
    output logic               rsp_cout_o,
    output logic [ID_W-1:0]    rsp_id_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic            cin_q, cin_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic [7:0]      rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic            handshake;
    logic [7:0]      add_sum;
    logic            add_cout;

    // The adder only ever sees the captured operands, so requester-side changes after accept are invisible.
    adder_8bit u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_vld && req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && !rst && grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign handshake = |(req_valid_i & req_ready_o);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        id_d       = id_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    a_d     = req_a_i[8*grant_idx +: 8];
                    b_d     = req_b_i[8*grant_idx +: 8];
                    cin_d   = req_cin_i[grant_idx];
                    id_d    = grant_idx;
                    state_d = CALC;
                end
            end
            CALC: begin
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_id_d   = id_q;
                rsp_vld_d  = 1'b1;
                rr_ptr_d   = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            id_q       <= id_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid_o = rsp_vld_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = (state_q != IDLE);
endmodule
